// File: rtl/router_pkg.sv
// router_pkg: shared port indices, port count and per-output arbiter state type
package router_pkg;
  localparam int NUM_PORTS = 4;
  localparam logic [1:0] PORT_A = 2'd0;
  localparam logic [1:0] PORT_B = 2'd1;
  localparam logic [1:0] PORT_C = 2'd2;
  localparam logic [1:0] PORT_D = 2'd3;
  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/crossbar_arbiter_rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin pick, scanning from ptr upward
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] win,
  output logic       valid
);
  // scan downward so the requester closest to ptr is written last and wins
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--) win = req[ptr + 2'(k)] ? ptr + 2'(k) : win;
  end
  assign valid = |req;
endmodule

// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter: per-output round-robin packet lock for the 4x4 crossbar; XBAR_ARB_TIMEOUT_EN adds owner-stall release
module crossbar_arbiter
  import router_pkg::*;
#(
  parameter int STALL_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_A,
  input  logic       req_B,
  input  logic       req_C,
  input  logic       req_D,
  input  logic [1:0] dest_A,
  input  logic [1:0] dest_B,
  input  logic [1:0] dest_C,
  input  logic [1:0] dest_D,
  input  logic       tail_A,
  input  logic       tail_B,
  input  logic       tail_C,
  input  logic       tail_D,
  input  logic       rdy_A,
  input  logic       rdy_B,
  input  logic       rdy_C,
  input  logic       rdy_D,
  output logic [1:0] sel_A,
  output logic [1:0] sel_B,
  output logic [1:0] sel_C,
  output logic [1:0] sel_D,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_D,
  output logic       gnt_A,
  output logic       gnt_B,
  output logic       gnt_C,
  output logic       gnt_D
);
  logic [NUM_PORTS-1:0] req, tail, rdy, en, gnt, valid;
  logic [1:0] dest [NUM_PORTS];
  logic [NUM_PORTS-1:0] oreq [NUM_PORTS];
  logic [1:0] win [NUM_PORTS];
  arb_state_t st_q [NUM_PORTS];
  arb_state_t st_d [NUM_PORTS];
  logic [1:0] owner_q [NUM_PORTS];
  logic [1:0] owner_d [NUM_PORTS];
  logic [1:0] ptr_q [NUM_PORTS];
  logic [1:0] ptr_d [NUM_PORTS];
`ifdef XBAR_ARB_TIMEOUT_EN
  localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);
  logic [7:0] cnt_q [NUM_PORTS];
  logic [7:0] cnt_d [NUM_PORTS];
`else
  logic unused_stall_limit;
  assign unused_stall_limit = ^STALL_LIMIT;
`endif
  assign req  = {req_D, req_C, req_B, req_A};
  assign tail = {tail_D, tail_C, tail_B, tail_A};
  assign rdy  = {rdy_D, rdy_C, rdy_B, rdy_A};
  assign dest[PORT_A] = dest_A;
  assign dest[PORT_B] = dest_B;
  assign dest[PORT_C] = dest_C;
  assign dest[PORT_D] = dest_D;
  // route each input's request to the output it is addressing
  always_comb
    for (int o = 0; o < NUM_PORTS; o++)
      for (int i = 0; i < NUM_PORTS; i++) oreq[o][i] = req[i] && dest[i] == 2'(o);
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    rr_arbiter4 u_rr (.req(oreq[g]), .ptr(ptr_q[g]), .win(win[g]), .valid(valid[g]));
  end
  // per-output lock: arbitrate when idle, stream the owner's flits, release on tail
  always_comb begin
    gnt = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      en[o] = st_q[o] == BUSY && req[owner_q[o]] && rdy[o];
      gnt[owner_q[o]] = gnt[owner_q[o]] | en[o];
      st_d[o] = st_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o] = ptr_q[o];
      if (st_q[o] == IDLE && valid[o]) begin
        st_d[o] = BUSY;
        owner_d[o] = win[o];
        ptr_d[o] = win[o] + 2'd1;
      end
      if (en[o] && tail[owner_q[o]]) st_d[o] = IDLE;
`ifdef XBAR_ARB_TIMEOUT_EN
      cnt_d[o] = cnt_q[o];
      if (st_q[o] == IDLE || en[o]) cnt_d[o] = '0;
      else if (!req[owner_q[o]]) begin
        cnt_d[o] = cnt_q[o] == STALL_LAST ? '0 : cnt_q[o] + 8'd1;
        if (cnt_q[o] == STALL_LAST) st_d[o] = IDLE;
      end
`endif
    end
  end
  // controller registers; reset drops every lock at once
  always_ff @(posedge clk)
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        st_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o] <= '0;
`ifdef XBAR_ARB_TIMEOUT_EN
        cnt_q[o] <= '0;
`endif
      end
    end else begin
      st_q <= st_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
`ifdef XBAR_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  assign {en_D, en_C, en_B, en_A} = en;
  assign {gnt_D, gnt_C, gnt_B, gnt_A} = gnt;
  assign sel_A = owner_q[PORT_A];
  assign sel_B = owner_q[PORT_B];
  assign sel_C = owner_q[PORT_C];
  assign sel_D = owner_q[PORT_D];
endmodule

// File: doc/crossbar_arbiter.md
# crossbar_arbiter

Switch allocator that sequences the 4×4 `crossbar_switch` datapath. Each of input ports A–D presents a request, a 2-bit destination and a tail flag. For each output port, the block picks one requester by round-robin and locks it until its tail flit transfers. It drives the crossbar's `sel_*`/`en_*` controls and returns a per-input grant that pops the input FIFO.

## Interface
- `STALL_LIMIT`, 16: cycles a locked owner may hold an output with `req` low before forced release. Used only with `XBAR_ARB_TIMEOUT_EN`. Range 2–255.
- `clk` in 1: single clock; every register updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_A`..`req_D` in 1: input FIFO non-empty; a flit is present.
- `dest_A`..`dest_D` in 2: destination output of the present flit (0=A, 1=B, 2=C, 3=D). Stable from head to tail.
- `tail_A`..`tail_D` in 1: the present flit is the last flit of its packet.
- `rdy_A`..`rdy_D` in 1: the downstream side of the output can accept a flit this cycle.
- `sel_A`..`sel_D` out 2: crossbar select per output; equals the owner index.
- `en_A`..`en_D` out 1: crossbar output enable; a flit transfers this cycle.
- `gnt_A`..`gnt_D` out 1: pop strobe to the input FIFO; high exactly when that input's flit transfers.

## Operation
- There is one independent controller per output o. Each has state `IDLE`/`BUSY`, `owner[1:0]`, round-robin pointer `ptr[1:0]` and, if configured, a stall counter.
- Input i requests output o when `req_i && dest_i==o`.
- **IDLE:**
  - If any input requests o, the winner is the first requester scanning i = ptr, ptr+1, … mod 4.
  - Next cycle: `owner<=winner`, `ptr<=winner+1` (mod 4, wraps 3→0), state `BUSY`.
  - No transfer occurs in the arbitration cycle.
- **BUSY:**
  - `en_o = req_owner && rdy_o` (combinational).
  - `gnt_owner = en_o`.
  - `sel_o = owner`.
  - If `en_o && tail_owner`: state `IDLE` next cycle; `owner` is retained.
- The `IDLE` → `BUSY` transition is registered, so an output never re-arbitrates in the cycle its tail transfers.
- An input has a single destination, so at most one output grants it. `gnt_i` is the OR over outputs of (`en_o && owner_o==i && BUSY_o`).
- Outputs with no requests stay `IDLE`; `ptr` is unchanged.
- Single-flit packet (head has `tail`=1): handled as above; the output is BUSY for exactly the transfer cycle(s).
- `rdy_o` low while BUSY: the lock is held, `en_o`=0, and no timeout counting occurs (backpressure is not a stall).

## Timing
- Reset: all states `IDLE`, `owner`=0, `ptr`=0, stall counters 0. `sel_*`=0, `en_*`=0, `gnt_*`=0 in the cycle after `rst` is sampled high.
- Reset mid-packet: all locks are dropped immediately. The upstream FIFO contents are not the arbiter's concern.
- Arbitration latency: a request seen at edge t (IDLE) gives the earliest transfer in cycle t+1.
- Throughput: one flit per cycle per output while BUSY with `req` and `rdy` both high.
- Back-to-back packets to the same output have a 1-cycle bubble: tail at cycle t, IDLE at t+1 (arbitrate), next transfer at t+2.
- Four outputs may all transfer in the same cycle when their destinations are distinct.

## Configuration
- `XBAR_ARB_TIMEOUT_EN` defined:
  - Each output has a stall counter, cleared on entering BUSY and on every transfer.
  - The counter increments while BUSY with `req_owner`=0.
  - On reaching `STALL_LIMIT`, the output returns to `IDLE` next cycle; `ptr` is already past the owner.
- Not defined: no counter logic. A BUSY output waits indefinitely for its owner's tail.

## Structure
- Shared package `router_pkg`:
  - port index constants `PORT_A`=0 … `PORT_D`=3;
  - `arb_state_t` enum {`IDLE`, `BUSY`};
  - `NUM_PORTS`=4.
- Sub-module `rr_arbiter4`: one per output. It takes a 4-bit request vector and `ptr`, and returns a winner index and a `valid` flag (combinational). The parent holds the state, owner, ptr and counter registers.

## Test plan
- Reset: after `rst`=1 for 2 cycles, all `en_*`/`gnt_*`=0 and `sel_*`=0. With `req_A`=1, `dest_A`=2 and reset held, no grant is issued.
- Single packet, 3 flits, A→C with `rdy_C`=1, request from cycle 0:
  - `en_C`=`gnt_A`=1 in cycles 1–3 with `sel_C`=0;
  - `en_C`=0 in cycle 4.
- Contention, A, B and D all targeting B with 1-flit packets held continuously:
  - grants go to A, B, D in that order, at cycles 1, 3, 5;
  - then wrap to A at cycle 7.
- Backpressure: B→D packet locked, `rdy_D` low for 5 cycles mid-packet. `en_D`=0 for those cycles, the lock is held, the remaining flits resume, and C requesting D is not granted until after B's tail.
- Parallel: A→B, B→A, C→D, D→C simultaneously gives all four `en_*`=1 in cycle 1, with `sel_A`=1, `sel_B`=0, `sel_C`=3, `sel_D`=2.
- Timeout (`XBAR_ARB_TIMEOUT_EN`, `STALL_LIMIT`=4): owner A→B drops `req_A` mid-packet. B goes IDLE after 4 stalled cycles, and a waiting C→B request is granted 1 cycle later.
